// File: rtl/alu_seq.sv
// Registered ALU with internal CCR {V,C,N,Z} and valid/ready input handshake.
// Define ALU_SEQ_MUL_EN to add an iterative shift-add multiplier on opcode 1111.
module alu_seq #(
    parameter int         WIDTH   = 8,
    parameter logic [3:0] CCR_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Alu_opcode,
    input  logic             flush,
    input  logic             ccr_load,
    input  logic [3:0]       ccr_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic [3:0]       ccr_out,
    output logic             busy
);

    localparam int W = WIDTH;

    logic [W-1:0] r_out;
    logic         r_valid;
    logic [3:0]   r_ccr;

    logic [W-1:0] w_res;
    logic [W:0]   w_sum;
    logic [3:0]   w_ccr;
    logic         w_nz;
    logic         w_acc;
    logic         w_is_mul;

    always_comb begin
        w_res = '0;
        w_sum = '0;
        w_ccr = r_ccr;
        w_nz  = 1'b1;
        case (Alu_opcode)
            4'h0: w_res = B;
            4'h1: begin
                w_sum    = {1'b0, A} + {1'b0, B};
                w_res    = w_sum[W-1:0];
                w_ccr[2] = w_sum[W];
                w_ccr[3] = (A[W-1] == B[W-1]) && (w_res[W-1] != A[W-1]);
            end
            4'h2: begin
                w_sum    = {1'b0, A} - {1'b0, B};
                w_res    = w_sum[W-1:0];
                w_ccr[2] = w_sum[W];
                w_ccr[3] = (A[W-1] != B[W-1]) && (w_res[W-1] != A[W-1]);
            end
            4'h3: w_res = A & B;
            4'h4: w_res = A | B;
            4'h5: begin
                w_res    = {B[W-2:0], r_ccr[2]};
                w_ccr[2] = B[W-1];
                w_ccr[3] = w_res[W-1] != B[W-1];
            end
            4'h6: begin
                w_res    = {r_ccr[2], B[W-1:1]};
                w_ccr[2] = B[0];
                w_ccr[3] = w_res[W-1] != B[W-1];
            end
            4'h7: begin
                w_ccr[2] = 1'b1;
                w_nz     = 1'b0;
            end
            4'h8: begin
                w_ccr[2] = 1'b0;
                w_nz     = 1'b0;
            end
            4'h9: w_res = ~B;
            4'hA: w_res = -B;
            4'hB: begin
                w_sum    = {1'b0, B} + (W+1)'(1);
                w_res    = w_sum[W-1:0];
                w_ccr[2] = w_sum[W];
                w_ccr[3] = !B[W-1] && w_res[W-1];
            end
            4'hC: begin
                w_sum    = {1'b0, B} - (W+1)'(1);
                w_res    = w_sum[W-1:0];
                w_ccr[2] = w_sum[W];
                w_ccr[3] = B[W-1] && !w_res[W-1];
            end
            4'hD: begin
                w_sum    = {1'b0, A} - (W+1)'(1);
                w_res    = w_sum[W-1:0];
                w_ccr[2] = w_sum[W];
                w_ccr[3] = A[W-1] && !w_res[W-1];
            end
            4'hE: w_res = A;
            default: begin
                w_ccr = 4'b0000;
                w_nz  = 1'b0;
            end
        endcase
        if (w_nz) begin
            w_ccr[1] = w_res[W-1];
            w_ccr[0] = (w_res == '0);
        end
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t         r_state;
    logic [2*W-1:0] r_mcand;
    logic [2*W-1:0] r_prod;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_cnt;
    logic [2*W-1:0] w_mul_nx;
    logic [3:0]     w_mul_ccr;
    logic           w_hi_nz;

    assign w_mul_nx  = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_hi_nz   = |w_mul_nx[2*W-1:W];
    assign w_mul_ccr = {w_hi_nz, w_hi_nz, w_mul_nx[W-1], w_mul_nx[W-1:0] == '0};
    assign w_is_mul  = (Alu_opcode == 4'hF);
    assign in_ready  = rst_n && (r_state == S_IDLE);
    assign busy      = (r_state == S_MUL);
`else
    assign w_is_mul  = 1'b0;
    assign in_ready  = rst_n;
    assign busy      = 1'b0;
`endif

    assign w_acc     = in_valid && in_ready && !flush;
    assign out       = r_out;
    assign out_valid = r_valid;
    assign ccr_out   = r_ccr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out    <= '0;
            r_valid  <= 1'b0;
            r_ccr    <= CCR_RST;
`ifdef ALU_SEQ_MUL_EN
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_acc && !w_is_mul) begin
                r_out   <= w_res;
                r_valid <= 1'b1;
                r_ccr   <= w_ccr;
            end
`ifdef ALU_SEQ_MUL_EN
            if (r_state == S_MUL) begin
                if (flush) begin
                    r_state <= S_IDLE;
                end else begin
                    r_prod   <= w_mul_nx;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    // last iteration: product is final on this edge
                    if (r_cnt == CW'(W-1)) begin
                        r_state <= S_IDLE;
                        r_out   <= w_mul_nx[W-1:0];
                        r_valid <= 1'b1;
                        r_ccr   <= w_mul_ccr;
                    end
                end
            end else if (w_acc && w_is_mul) begin
                r_state  <= S_MUL;
                r_mcand  <= {{W{1'b0}}, A};
                r_mplier <= B;
                r_prod   <= '0;
                r_cnt    <= '0;
            end
`endif
            // a restore overrides any flag update on the same edge
            if (ccr_load) r_ccr <= ccr_in;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=8, CCR_RST=0).
// MUL vectors run when ALU_SEQ_MUL_EN is defined, else 1111 is checked as invalid.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] Alu_opcode;
    logic       flush;
    logic       ccr_load;
    logic [3:0] ccr_in;
    logic       out_valid;
    logic [7:0] out;
    logic [3:0] ccr_out;
    logic       busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_seq #(.WIDTH(8), .CCR_RST(4'b0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Alu_opcode(Alu_opcode),
        .flush     (flush),
        .ccr_load  (ccr_load),
        .ccr_in    (ccr_in),
        .out_valid (out_valid),
        .out       (out),
        .ccr_out   (ccr_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b);
        Alu_opcode = op;
        A          = a;
        B          = b;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
        ccr_load = 1'b0;
    endtask

    task automatic res(input string tag, input logic [7:0] eo,
                       input logic [3:0] ec);
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_out"}, {24'd0, out}, {24'd0, eo});
        check({tag, "_ccr"}, {28'd0, ccr_out}, {28'd0, ec});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        A = 8'h00;
        B = 8'h00;
        Alu_opcode = 4'h0;
        ccr_in = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, in_ready}, 32'd0);
        check("rst_out", {24'd0, out}, 32'h0);
        check("rst_ccr", {28'd0, ccr_out}, 32'h0);
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_rdy", {31'd0, in_ready}, 32'd1);

        @(negedge clk);
        issue(4'h1, 8'h7F, 8'h01);
        res("add", 8'h80, 4'b1010);
        idle();
        @(posedge clk);
        #1;
        check("hold_vld", {31'd0, out_valid}, 32'd0);
        check("hold_out", {24'd0, out}, 32'h80);

        issue(4'h2, 8'h00, 8'h01);
        res("sub", 8'hFF, 4'b0110);
        issue(4'h5, 8'h00, 8'h00);
        res("rlc_b2b", 8'h01, 4'b0000);
        idle();

        ccr_load = 1'b1;
        ccr_in   = 4'b0001;
        issue(4'h1, 8'h01, 8'h01);
        res("collide", 8'h02, 4'b0001);
        idle();

        issue(4'h7, 8'h00, 8'h00);
        res("setc", 8'h00, 4'b0101);
        issue(4'h6, 8'h00, 8'h02);
        res("rrc", 8'h81, 4'b1010);
        issue(4'hD, 8'h80, 8'h00);
        res("deca", 8'h7F, 4'b1000);
        issue(4'hB, 8'h00, 8'hFF);
        res("incb", 8'h00, 4'b0101);

        flush = 1'b1;
        issue(4'h3, 8'hFF, 8'hFF);
        check("fl_idle_vld", {31'd0, out_valid}, 32'd0);
        check("fl_idle_out", {24'd0, out}, 32'h00);
        check("fl_idle_ccr", {28'd0, ccr_out}, 32'h5);
        idle();

        issue(4'hA, 8'h00, 8'h01);
        res("neg", 8'hFF, 4'b0110);
        idle();

        ccr_load = 1'b1;
        ccr_in   = 4'b1111;
        @(posedge clk);
        #1;
        idle();
        check("ld_ccr", {28'd0, ccr_out}, 32'hF);
        check("ld_vld", {31'd0, out_valid}, 32'd0);
        issue(4'h5, 8'h00, 8'h80);
        res("rlc_c", 8'h01, 4'b1100);
        issue(4'hC, 8'h00, 8'h00);
        res("decb", 8'hFF, 4'b0110);
        idle();

`ifdef ALU_SEQ_MUL_EN
        issue(4'hF, 8'h10, 8'h20);
        idle();
        for (int k = 0; k < 8; k++) begin
            check("mul_rdy", {31'd0, in_ready}, 32'd0);
            check("mul_busy", {31'd0, busy}, 32'd1);
            check("mul_vld", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        res("mul", 8'h00, 4'b1101);
        check("mul_done_rdy", {31'd0, in_ready}, 32'd1);

        issue(4'hF, 8'h03, 8'h05);
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("mfl_rdy", {31'd0, in_ready}, 32'd1);
        check("mfl_busy", {31'd0, busy}, 32'd0);
        check("mfl_ccr", {28'd0, ccr_out}, 32'hD);
        for (int k = 0; k < 10; k++) begin
            check("mfl_vld", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
        end

        issue(4'hF, 8'h0F, 8'h0F);
        idle();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
`else
        issue(4'hF, 8'h12, 8'h34);
        res("inval", 8'h00, 4'b0000);
        check("inval_busy", {31'd0, busy}, 32'd0);
        idle();
        issue(4'h1, 8'h0F, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
`endif
        check("arst_out", {24'd0, out}, 32'h0);
        check("arst_ccr", {28'd0, ccr_out}, 32'h0);
        check("arst_rdy", {31'd0, in_ready}, 32'd0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
